rr_mux: RTL

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output, and two selection modes: round-robin arbitration and fixed (software-selected) channel. It is the successor to the plain combinational 4:1 datapath mux. It sits where several producers (e.g. writeback sources, memory response ports) share one consumer and need fair, back-pressured access.

---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/rr_mux.sv | 119 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Purpose : shared mode encodings, output-register state type and select-width helper for rr_mux.
// Latency : none (declarations only).
// Backpressure: none (declarations only).
package mux_pkg;

    localparam logic MUX_MODE_RR    = 1'b0;
    localparam logic MUX_MODE_FIXED = 1'b1;

    // Occupancy of the single-entry output register.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // Select width that never collapses to zero bits, so a select port
    // always exists even for the smallest channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : round-robin grant search over N requests, starting at ptr and wrapping mod N.
// Latency : purely combinational (0 cycles); the pointer register lives in the parent.
// Backpressure: en = 0 suppresses every grant; the requests themselves are never stalled here.
//
// Ports: req[N] requests, ptr start position, en grant enable;
//        grant one-hot or zero, grant_idx encoded winner, grant_valid any grant issued.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] grant_idx,
    output logic            grant_valid
);

    int              pos;
    logic [SELW-1:0] cand;
    logic            found;
    logic [SELW-1:0] found_idx;

    always_comb begin
        pos       = 0;
        cand      = '0;
        found     = 1'b0;
        found_idx = '0;
        // Walk from the farthest candidate back towards ptr: the last hit
        // written is the requester nearest to ptr, which is the winner.
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            cand = SELW'(pos);
            if (req[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end

        grant_valid = en && found;
        grant_idx   = found_idx;
        grant       = '0;
        if (grant_valid) begin
            grant[found_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux.sv
// Purpose : N-channel registered mux with valid/ready on every input and the output; round-robin or fixed select.
// Latency : 1 cycle from input handshake to out_data; 1 word/cycle while out_ready stays high.
// Backpressure: in_ready is all-zero while the held word is not being drained (out_valid && !out_ready) and during reset.
//
// Ports: clk, rst (async, active-high); in_valid[N], in_data[N*WIDTH] (channel i at [i*WIDTH +: WIDTH]),
//        in_ready[N] one-hot or zero; mode (0 round-robin, 1 fixed), fixed_sel;
//        out_valid, out_data, out_sel (source channel of out_data), out_ready.
module rr_mux
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int SELW  = clog2_min1(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      fixed_sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    out_state_t       state_q;
    out_state_t       state_d;
    logic [SELW-1:0]  ptr_q;
    logic [SELW-1:0]  ptr_nxt;

    logic             load_en;
    logic             rr_en;
    logic [N-1:0]     rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_vld;

    logic [N-1:0]     fx_onehot;
    logic             fx_vld;
    logic [N-1:0]     fx_gnt;

    logic [N-1:0]     gnt;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_vld;
    logic [WIDTH-1:0] gnt_word;

    assign out_valid = (state_q == OUT_FULL);

    // The register can take a word when it is empty or is being drained this cycle.
    assign load_en = !out_valid || out_ready;
    assign rr_en   = load_en && (mode == MUX_MODE_RR);

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_q),
        .en          (rr_en),
        .grant       (rr_gnt),
        .grant_idx   (rr_idx),
        .grant_valid (rr_vld)
    );

    // Shifting a one past the top bit yields zero, so a fixed_sel outside
    // 0..N-1 simply matches no request and never produces a grant.
    assign fx_onehot = N'(1) << fixed_sel;
    assign fx_vld    = load_en && (mode == MUX_MODE_FIXED) && (|(in_valid & fx_onehot));
    assign fx_gnt    = fx_vld ? fx_onehot : '0;

    always_comb begin
        gnt     = rr_gnt;
        gnt_idx = rr_idx;
        gnt_vld = rr_vld;
        if (mode == MUX_MODE_FIXED) begin
            gnt     = fx_gnt;
            gnt_idx = fixed_sel;
            gnt_vld = fx_vld;
        end
    end

    // Flops already sit in reset while rst is high, but the grant logic would
    // still see an empty register; mask it so no producer thinks it transferred.
    assign in_ready = rst ? '0 : gnt;

    assign gnt_word = in_data[int'(gnt_idx) * WIDTH +: WIDTH];
    assign ptr_nxt  = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);

    always_comb begin
        state_d = state_q;
        if (gnt_vld) begin
            state_d = OUT_FULL;
        end else if (out_ready) begin
            state_d = OUT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OUT_EMPTY;
            ptr_q    <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_vld) begin
                out_data <= gnt_word;
                out_sel  <= gnt_idx;
                // Fixed mode leaves the rotation untouched so round-robin
                // resumes where it left off.
                if (mode == MUX_MODE_RR) begin
                    ptr_q <= ptr_nxt;
                end
            end
        end
    end

endmodule
